// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer gating PC, register-file and data-memory commits.
// Optional watchdog trip into a sticky TRIP state when CPU_WATCHDOG_EN is defined.
module cpu_run_ctrl #(
    parameter int PC_W       = 16,
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             cu_reg_write,
    input  logic             cu_mem_write,
    output logic             pc_en,
    output logic             reg_write,
    output logic             mem_write,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

`ifdef CPU_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_HALT  = 3'd2,
        S_BREAK = 3'd3,
        S_STEP  = 3'd4,
        S_TRIP  = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_halted;
    logic             r_resume_skip;
    logic [CNT_W-1:0] r_count;

    logic             w_bp_hit;
    logic             w_exec;
    logic             w_wdog_trip;
    logic [CNT_W-1:0] w_cnt_next;

    // Commit decision is combinational so the current instruction can be blocked in its own cycle.
    always_comb begin
        w_bp_hit    = bp_en && (pc == bp_addr) && !r_resume_skip;
        w_exec      = !reset && (((r_state == S_RUN) && !stop && !w_bp_hit) || (r_state == S_STEP));
        w_cnt_next  = (&r_count) ? r_count : r_count + 1'b1;
        w_wdog_trip = WDOG_ON && (r_state == S_RUN) && w_exec && (w_cnt_next == CNT_W'(WDOG_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_halted      <= 1'b0;
            r_resume_skip <= 1'b0;
            r_count       <= '0;
        end else begin
            if (w_exec) r_count <= w_cnt_next;
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_RUN;
                end
                S_RUN: begin
                    r_resume_skip <= 1'b0;
                    if (stop) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (w_bp_hit) begin
                        r_state  <= S_BREAK;
                        r_halted <= 1'b1;
                    end else if (w_wdog_trip) begin
                        r_state  <= S_TRIP;
                        r_halted <= 1'b1;
                    end
                end
                S_HALT, S_BREAK: begin
                    // Skip flag lets the breakpoint instruction execute once on resume.
                    if (start) begin
                        r_state       <= S_RUN;
                        r_halted      <= 1'b0;
                        r_resume_skip <= 1'b1;
                    end else if (step) begin
                        r_state       <= S_STEP;
                        r_halted      <= 1'b0;
                        r_resume_skip <= 1'b1;
                    end
                end
                S_STEP: begin
                    r_resume_skip <= 1'b0;
                    r_state       <= S_HALT;
                    r_halted      <= 1'b1;
                end
                S_TRIP: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign pc_en       = w_exec;
    assign reg_write   = cu_reg_write & w_exec;
    assign mem_write   = cu_mem_write & w_exec;
    assign state       = r_state;
    assign halted      = r_halted;
    assign instr_count = r_count;

endmodule
